hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_hazard_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch flush and memory-freeze control for an
// in-order pipeline. Outputs are combinational from state and current inputs.
// Optional build macro HAZARD_CTRL_PERF_EN adds stall/flush cycle counters
// (stall_cnt_o, flush_cnt_o); without it those ports and registers do not exist.
module hazard_ctrl #(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             memread_idex_i,
  input  logic [REG_W-1:0] rd_idex_i,
  input  logic [REG_W-1:0] rs1_ifid_i,
  input  logic [REG_W-1:0] rs2_ifid_i,
  input  logic             rs1_used_i,
  input  logic             rs2_used_i,
  input  logic             id_equal_i,
  input  logic             is_branch_i,
  input  logic             mem_stall_i,
  output logic             pc_write_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             bubble_o,
`ifdef HAZARD_CTRL_PERF_EN
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
`endif
  output logic             busy_o
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_LDSTALL = 2'd1;
  localparam logic [1:0] ST_MEMWAIT = 2'd2;

  // Elaboration-time guard on the legal parameter ranges.
  if (LOAD_LAT < 1 || LOAD_LAT > 7 || CNT_W < 1 || REG_W < 1) begin : g_param_check
    $error("hazard_ctrl: illegal parameter value");
  end

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [2:0]       cnt;
  logic [2:0]       cnt_nxt;
  logic [REG_W-1:0] lat_rd;
  logic [REG_W-1:0] lat_rd_nxt;
  logic             hazard;
  logic             branch_taken;

  // Load-use hazard: load in EX writes a nonzero register read by the ID instruction.
  always_comb begin
    hazard = memread_idex_i && (rd_idex_i != '0) &&
             ((rs1_used_i && (rd_idex_i == rs1_ifid_i)) ||
              (rs2_used_i && (rd_idex_i == rs2_ifid_i)));
    branch_taken = id_equal_i && is_branch_i;
  end

  // State, stall counter and latched load destination.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= ST_RUN;
      cnt    <= 3'd0;
      lat_rd <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      lat_rd <= lat_rd_nxt;
    end
  end

  // Next state: memory freeze holds everything; MEMWAIT resumes as RUN.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    lat_rd_nxt = lat_rd;
    if (mem_stall_i) begin
      if (state == ST_RUN) state_nxt = ST_MEMWAIT;
    end else begin
      case (state)
        ST_LDSTALL: begin
          cnt_nxt = cnt - 3'd1;
          if (cnt == 3'd1) state_nxt = ST_RUN;
        end
        default: begin
          state_nxt = ST_RUN;
          if (hazard && (LOAD_LAT > 1)) begin
            state_nxt  = ST_LDSTALL;
            cnt_nxt    = 3'(LOAD_LAT - 1);
            lat_rd_nxt = rd_idex_i;
          end
        end
      endcase
    end
  end

  // Output decode by priority: reset, freeze, load stall, hazard, branch flush.
  always_comb begin
    pc_write_o   = 1'b1;
    ifid_stall_o = 1'b0;
    ifid_flush_o = 1'b0;
    bubble_o     = 1'b0;
    busy_o       = 1'b0;
    if (!rst_i) begin
      busy_o = (state != ST_RUN);
      if (mem_stall_i) begin
        pc_write_o   = 1'b0;
        ifid_stall_o = 1'b1;
      end else if (state == ST_LDSTALL || hazard) begin
        pc_write_o   = 1'b0;
        ifid_stall_o = 1'b1;
        bubble_o     = 1'b1;
      end else if (branch_taken) begin
        ifid_flush_o = 1'b1;
        bubble_o     = 1'b1;
      end
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  // Stall and flush cycle counters; wrap naturally and hold during freeze.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else if (!mem_stall_i) begin
      if (bubble_o && !ifid_flush_o) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (ifid_flush_o)              flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: two instances (LOAD_LAT=1 and 3)
// share the stimulus; expected output vectors are queued per step and popped
// when the outputs are sampled mid-cycle.
module tb_hazard_ctrl;

  // Expected vector layout: {pc_write, ifid_stall, ifid_flush, bubble, busy}
  localparam logic [4:0] IDLE = 5'b10000;
  localparam logic [4:0] IDLB = 5'b10001;
  localparam logic [4:0] STL  = 5'b01010;
  localparam logic [4:0] STLB = 5'b01011;
  localparam logic [4:0] FRZ  = 5'b01000;
  localparam logic [4:0] FRZB = 5'b01001;
  localparam logic [4:0] FLU  = 5'b10110;

  logic       clk = 1'b0;
  logic       rst;
  logic       memread;
  logic [4:0] rd, rs1, rs2;
  logic       used1, used2, equal, branch, mstall;

  logic pc1, st1, fl1, bb1, by1;
  logic pc3, st3, fl3, bb3, by3;
  logic [4:0] obs1, obs3;

  int ncmp  = 0;
  int nfail = 0;

  typedef struct {
    string      tag;
    logic [4:0] e1;
    logic [4:0] e3;
    logic       rst;
    logic       ms;
  } exp_t;
  exp_t sb[$];

`ifdef HAZARD_CTRL_PERF_EN
  logic [7:0] sc1, fc1, sc3, fc3;
  logic [7:0] m_sc1 = '0, m_fc1 = '0, m_sc3 = '0, m_fc3 = '0;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(5), .LOAD_LAT(1), .CNT_W(8)) u_lat1 (
    .clk_i(clk), .rst_i(rst), .memread_idex_i(memread), .rd_idex_i(rd),
    .rs1_ifid_i(rs1), .rs2_ifid_i(rs2), .rs1_used_i(used1), .rs2_used_i(used2),
    .id_equal_i(equal), .is_branch_i(branch), .mem_stall_i(mstall),
    .pc_write_o(pc1), .ifid_stall_o(st1), .ifid_flush_o(fl1), .bubble_o(bb1),
`ifdef HAZARD_CTRL_PERF_EN
    .stall_cnt_o(sc1), .flush_cnt_o(fc1),
`endif
    .busy_o(by1)
  );

  hazard_ctrl #(.REG_W(5), .LOAD_LAT(3), .CNT_W(8)) u_lat3 (
    .clk_i(clk), .rst_i(rst), .memread_idex_i(memread), .rd_idex_i(rd),
    .rs1_ifid_i(rs1), .rs2_ifid_i(rs2), .rs1_used_i(used1), .rs2_used_i(used2),
    .id_equal_i(equal), .is_branch_i(branch), .mem_stall_i(mstall),
    .pc_write_o(pc3), .ifid_stall_o(st3), .ifid_flush_o(fl3), .bubble_o(bb3),
`ifdef HAZARD_CTRL_PERF_EN
    .stall_cnt_o(sc3), .flush_cnt_o(fc3),
`endif
    .busy_o(by3)
  );

  assign obs1 = {pc1, st1, fl1, bb1, by1};
  assign obs3 = {pc3, st3, fl3, bb3, by3};

  task automatic drive(input logic mr, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic u1, input logic u2,
                       input logic eq, input logic br, input logic ms, input logic r);
    memread = mr; rd = d; rs1 = s1; rs2 = s2; used1 = u1; used2 = u2;
    equal = eq; branch = br; mstall = ms; rst = r;
  endtask

  task automatic idle_in();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One cycle: queue expectation, sample 2 time units after the falling edge.
  task automatic step(input string tag, input logic [4:0] e1, input logic [4:0] e3);
    exp_t e;
    exp_t g;
    e.tag = tag; e.e1 = e1; e.e3 = e3; e.rst = rst; e.ms = mstall;
    sb.push_back(e);
    #2;
    g = sb.pop_front();
    ncmp++;
    assert (obs1 === g.e1) else begin
      nfail++;
      $error("FAIL %s lat1 observed=%b expected=%b", g.tag, obs1, g.e1);
    end
    ncmp++;
    assert (obs3 === g.e3) else begin
      nfail++;
      $error("FAIL %s lat3 observed=%b expected=%b", g.tag, obs3, g.e3);
    end
`ifdef HAZARD_CTRL_PERF_EN
    ncmp++;
    assert ({sc1, fc1, sc3, fc3} === {m_sc1, m_fc1, m_sc3, m_fc3}) else begin
      nfail++;
      $error("FAIL %s perf observed=%h/%h/%h/%h expected=%h/%h/%h/%h", g.tag,
             sc1, fc1, sc3, fc3, m_sc1, m_fc1, m_sc3, m_fc3);
    end
    if (g.rst) begin
      m_sc1 = '0; m_fc1 = '0; m_sc3 = '0; m_fc3 = '0;
    end else if (!g.ms) begin
      if (g.e1[1] && !g.e1[2]) m_sc1 = m_sc1 + 8'd1;
      if (g.e1[2])             m_fc1 = m_fc1 + 8'd1;
      if (g.e3[1] && !g.e3[2]) m_sc3 = m_sc3 + 8'd1;
      if (g.e3[2])             m_fc3 = m_fc3 + 8'd1;
    end
`endif
    @(negedge clk);
  endtask

  initial begin
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    step("rst_a", IDLE, IDLE);
    step("rst_b", IDLE, IDLE);
    idle_in();
    step("idle", IDLE, IDLE);

    // load-use on rs1
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_c1", STL, STL);
    idle_in();
    step("lu_c2", IDLE, STLB);
    step("lu_c3", IDLE, STLB);
    step("lu_done", IDLE, IDLE);

    // load-use on rs2
    drive(1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rs2_c1", STL, STL);
    idle_in();
    step("rs2_c2", IDLE, STLB);
    step("rs2_c3", IDLE, STLB);
    step("rs2_done", IDLE, IDLE);

    // cases that must not stall
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("x0_rd", IDLE, IDLE);
    drive(1'b1, 5'd6, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("x0_rs1", IDLE, IDLE);
    drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rs2_unused", IDLE, IDLE);
    drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rs1_unused", IDLE, IDLE);
    drive(1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("no_load", IDLE, IDLE);

    // memory freeze in the middle of a load stall
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("fz_c1", STL, STL);
    idle_in();
    step("fz_c2", IDLE, STLB);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("fz_m1", FRZ, FRZB);
    step("fz_m2", FRZB, FRZB);
    idle_in();
    step("fz_c3", IDLB, STLB);
    step("fz_done", IDLE, IDLE);

    // branch flush
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step("br_taken", FLU, FLU);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("br_not_taken", IDLE, IDLE);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("not_branch", IDLE, IDLE);

    // hazard beats branch; branch resolves after the stall
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step("hb_c1", STL, STL);
    drive(1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step("hb_c2", FLU, STLB);
    step("hb_c3", FLU, STLB);
    step("hb_c4", FLU, FLU);
    idle_in();
    step("hb_done", IDLE, IDLE);

    // freeze takes priority over a fresh hazard, then hazard from MEMWAIT
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("ms_hz", FRZ, FRZ);
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("mw_hz", STLB, STLB);
    idle_in();
    step("mw_c2", IDLE, STLB);
    step("mw_c3", IDLE, STLB);
    step("mw_done", IDLE, IDLE);

    // reset abandons a stall in progress
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rs_c1", STL, STL);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("rs_rst", IDLE, IDLE);
    idle_in();
    step("rs_after", IDLE, IDLE);
    step("rs_after2", IDLE, IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
